// File: rtl/fsm_input_debouncer.sv
// Input conditioner for the command FSM: per-bit synchroniser chain followed by
// a disagreement-counter debouncer, with a registered change pulse.
module fsm_input_debouncer #(
   parameter int WIDTH           = 3,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] user_input,
   output logic             changed,
   output logic             stable
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [CNT_W-1:0] cnt        [WIDTH];
   logic [CNT_W-1:0] cnt_nxt    [WIDTH];
   logic [WIDTH-1:0] ui_nxt;
   logic [WIDTH-1:0] commit;

   assign sync = sync_chain[SYNC_STAGES-1];

   // State register: synchroniser chain, counters, committed vector, pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_chain[s] <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
         user_input <= '0;
         changed    <= 1'b0;
      end else begin
         sync_chain[0] <= raw_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_chain[s] <= sync_chain[s-1];
         for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
         user_input <= ui_nxt;
         changed    <= |commit;
      end
   end

   // Next state: a bit commits once it has disagreed for DEBOUNCE_CYCLES edges.
   always_comb begin
      ui_nxt = user_input;
      commit = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = '0;
         if (sync[i] != user_input[i]) begin
            if (cnt[i] == CNT_MAX) begin
               commit[i] = 1'b1;
               ui_nxt[i] = sync[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Output: no pending disagreement on any bit.
   always_comb begin
      stable = (sync == user_input);
   end

endmodule
